imem_port_arbiter: RTL and testbench

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

---
 rtl/imem_port_arbiter_pkg.sv | 15 +
 rtl/imem_load_counter.sv | 31 +++
 rtl/imem_port_arbiter.sv | 95 +++++++++
 tb/tb_imem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter:
// state encodings and default memory geometry.
package imem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LOAD     = 2'b01,
        WAIT_RUN = 2'b10,
        RUN      = 2'b11
    } state_t;

endpackage

// File: rtl/imem_load_counter.sv
// Counts words accepted during a program load; clear wins over increment
// and the count holds once it reaches the full memory size 2^ADDR_W.
module imem_load_counter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] C_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous-read program memory port between the UART loader
// (LOAD state) and the CPU fetch unit (RUN state), and holds the CPU in reset otherwise.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode_sw,
    input  logic              uart_valid,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_data,
    input  logic              uart_done,
    output logic              uart_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rst_n,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   load_count
);

    state_t r_state;
    state_t w_next;
    logic   r_pend;
    logic   w_uartAcc;
    logic   w_fetchAcc;
    logic   w_clear;

    // Accepts are gated by reset so nothing reaches the memory while reset is held.
    assign w_uartAcc  = reset && (r_state == LOAD) && uart_valid;
    assign w_fetchAcc = reset && (r_state == RUN) && fetch_req && !mode_sw;
    assign w_clear    = reset && (w_next == LOAD) && (r_state != LOAD);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_fetchAcc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = mode_sw ? LOAD : RUN;
            LOAD:     w_next = uart_done ? WAIT_RUN : LOAD;
            WAIT_RUN: w_next = mode_sw ? WAIT_RUN : RUN;
            RUN:      w_next = mode_sw ? LOAD : RUN;
            default:  w_next = IDLE;
        endcase
    end

    // A pending ack is always presented in the RUN cycle where mode_sw rises,
    // so leaving RUN on that same edge never drops it.
    always_comb begin
        uart_ready = w_uartAcc;
        mem_en     = w_uartAcc || w_fetchAcc;
        mem_we     = w_uartAcc;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (w_uartAcc) begin
            mem_addr  = uart_addr;
            mem_wdata = uart_data;
        end else if (w_fetchAcc) begin
            mem_addr = fetch_addr;
        end
        fetch_ack  = reset && r_pend;
        fetch_data = fetch_ack ? mem_rdata : '0;
        cpu_rst_n  = reset && (r_state == RUN);
    end

    assign state = r_state;

    imem_load_counter #(
        .ADDR_W (ADDR_W)
    ) u_load_counter (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .inc   (w_uartAcc),
        .count (load_count)
    );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: steps driven on the falling edge,
// outputs checked 1ns later against hand-computed values.
module tb_imem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        mode_sw;
    logic        uart_valid;
    logic [13:0] uart_addr;
    logic [31:0] uart_data;
    logic        uart_done;
    logic        uart_ready;
    logic        fetch_req;
    logic [13:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        mem_en;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_rst_n;
    logic [1:0]  state;
    logic [14:0] load_count;

    int assertCount = 0;
    int failCount   = 0;

    logic        memClr = 1'b1;
    logic [63:0] written;
    logic [31:0] mem [0:63];

    always #5 clock = ~clock;

    imem_port_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .mode_sw    (mode_sw),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_data  (uart_data),
        .uart_done  (uart_done),
        .uart_ready (uart_ready),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_rst_n  (cpu_rst_n),
        .state      (state),
        .load_count (load_count)
    );

    // Program memory model: unwritten words read back as 0xA5000000 | address.
    always @(posedge clock) begin
        if (memClr) begin
            written <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[5:0]]     <= mem_wdata;
                written[mem_addr[5:0]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[5:0]] ? mem[mem_addr[5:0]]
                                                    : (32'hA500_0000 | {26'd0, mem_addr[5:0]});
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic mode, input logic uv,
                                 input logic [13:0] ua, input logic [31:0] ud,
                                 input logic udone, input logic freq, input logic [13:0] fa);
        @(negedge clock);
        reset      = rst;
        mode_sw    = mode;
        uart_valid = uv;
        uart_addr  = ua;
        uart_data  = ud;
        uart_done  = udone;
        fetch_req  = freq;
        fetch_addr = fa;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0; mode_sw = 1'b0; uart_valid = 1'b0; uart_addr = '0;
        uart_data = '0; uart_done = 1'b0; fetch_req = 1'b0; fetch_addr = '0;

        // Reset held with stray loader and fetch activity
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 1, 5);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 1, 5);
        memClr = 1'b0;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_load_count", load_count, 0);
        checkOutput("rst_uart_ready", uart_ready, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_fetch_ack", fetch_ack, 0);
        checkOutput("rst_cpu_rst_n", cpu_rst_n, 0);

        // Release into run mode, fetch 0x005
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 5);
        checkOutput("idle_state", state, 0);
        checkOutput("idle_mem_en", mem_en, 0);
        checkOutput("idle_fetch_ack", fetch_ack, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 5);
        checkOutput("run_state", state, 3);
        checkOutput("run_cpu_rst_n", cpu_rst_n, 1);
        checkOutput("f5_mem_en", mem_en, 1);
        checkOutput("f5_mem_we", mem_we, 0);
        checkOutput("f5_mem_addr", mem_addr, 14'h005);
        checkOutput("f5_ack_early", fetch_ack, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("f5_ack", fetch_ack, 1);
        checkOutput("f5_data", fetch_data, 32'hA500_0005);
        checkOutput("f5_idle_mem_en", mem_en, 0);
        applyStimulus(1, 0, 1, 14'h9, 32'h1234, 0, 0, 0);
        checkOutput("f5_ack_done", fetch_ack, 0);
        checkOutput("f5_data_zero", fetch_data, 0);
        checkOutput("run_uart_ready", uart_ready, 0);
        checkOutput("run_uart_mem_en", mem_en, 0);

        // Four back-to-back fetches 0x000..0x003
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 0, 0, 32'h0, 0, (k < 4), 14'(k));
            checkOutput("b2b_mem_en", mem_en, (k < 4) ? 1 : 0);
            if (k < 4) checkOutput("b2b_mem_addr", mem_addr, 64'(k));
            checkOutput("b2b_ack", fetch_ack, (k > 0) ? 1 : 0);
            if (k > 0) checkOutput("b2b_data", fetch_data, 32'hA500_0000 + 32'(k - 1));
        end

        // Switch to load, write three words, then uart_done
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("sw_state_run", state, 3);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("load_state", state, 1);
        checkOutput("load_cpu_rst_n", cpu_rst_n, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 1, 14'(k), 32'hDEAD_0000 + 32'(k), 0, 1, 9);
            checkOutput("ld_uart_ready", uart_ready, 1);
            checkOutput("ld_mem_en", mem_en, 1);
            checkOutput("ld_mem_we", mem_we, 1);
            checkOutput("ld_mem_addr", mem_addr, 64'(k));
            checkOutput("ld_mem_wdata", mem_wdata, 32'hDEAD_0000 + 32'(k));
            checkOutput("ld_load_count", load_count, 64'(k));
        end
        applyStimulus(1, 1, 0, 0, 32'h0, 1, 0, 0);
        checkOutput("done_mem_en", mem_en, 0);
        checkOutput("done_load_count", load_count, 3);
        checkOutput("done_state", state, 1);
        applyStimulus(1, 1, 1, 3, 32'h5555, 0, 0, 0);
        checkOutput("wait_state", state, 2);
        checkOutput("wait_load_count", load_count, 3);
        checkOutput("wait_uart_ready", uart_ready, 0);
        checkOutput("wait_mem_en", mem_en, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("wait_hold_state", state, 2);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 1);
        checkOutput("rerun_state", state, 3);
        checkOutput("rerun_mem_en", mem_en, 1);

        // Loaded word reads back; mode_sw rises after an accepted fetch
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 7);
        checkOutput("loaded_ack", fetch_ack, 1);
        checkOutput("loaded_data", fetch_data, 32'hDEAD_0001);
        checkOutput("f7_mem_en", mem_en, 1);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 1, 8);
        checkOutput("sw_no_fetch", mem_en, 0);
        checkOutput("sw_ack", fetch_ack, 1);
        checkOutput("sw_data", fetch_data, 32'hA500_0007);
        checkOutput("sw_state", state, 3);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("sw_load_state", state, 1);
        checkOutput("sw_cpu_rst_n", cpu_rst_n, 0);
        checkOutput("sw_load_count", load_count, 0);
        checkOutput("sw_ack_after", fetch_ack, 0);

        // uart_valid and uart_done together at 0x010
        applyStimulus(1, 1, 1, 14'h10, 32'hCAFE_0010, 1, 0, 0);
        checkOutput("vd_uart_ready", uart_ready, 1);
        checkOutput("vd_mem_addr", mem_addr, 14'h010);
        checkOutput("vd_mem_wdata", mem_wdata, 32'hCAFE_0010);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("vd_state", state, 2);
        checkOutput("vd_load_count", load_count, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 14'h10);
        checkOutput("vd_run_state", state, 3);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("vd_data", fetch_data, 32'hCAFE_0010);

        // Reset in the middle of a load
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 1, 1, 14'h20, 32'h1111_1111, 0, 0, 0);
        checkOutput("rl_state", state, 1);
        applyStimulus(1, 1, 1, 14'h21, 32'h2222_2222, 0, 0, 0);
        checkOutput("rl_count1", load_count, 1);
        applyStimulus(0, 1, 1, 14'h22, 32'h3333_3333, 0, 0, 0);
        checkOutput("rl_in_rst_ready", uart_ready, 0);
        checkOutput("rl_in_rst_mem_en", mem_en, 0);
        applyStimulus(1, 1, 1, 14'h23, 32'h4444_4444, 0, 0, 0);
        checkOutput("rl_state_idle", state, 0);
        checkOutput("rl_count_zero", load_count, 0);
        checkOutput("rl_mem_en", mem_en, 0);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("rl_reload_state", state, 1);

        // Load counter saturates at 2^ADDR_W
        for (int k = 0; k < 16390; k++) begin
            applyStimulus(1, 1, 1, 14'(k), 32'(k), 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 0, 32'h0, 1, 0, 0);
        checkOutput("sat_load_count", load_count, 15'h4000);

        // Reset during a fetch drops the ack
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1, 2);
        checkOutput("rf_state", state, 3);
        checkOutput("rf_mem_en", mem_en, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("rf_ack_in_rst", fetch_ack, 0);
        checkOutput("rf_cpu_rst_n", cpu_rst_n, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0);
        checkOutput("rf_ack_after", fetch_ack, 0);
        checkOutput("rf_state_idle", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
